// File: rtl/oc8051_trace_capture.sv
`default_nettype none
// ============================================================================
// Module  : oc8051_trace_capture
// Brief   : Timestamped PC / memory-strobe trace recorder with FWFT drain port
// Revision: 1.0
// ============================================================================
module oc8051_trace_capture #(
    parameter int DEPTH_LOG2 = 6,
    parameter int TS_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [15:0]           pc,
    input  logic                  wr,
    input  logic [7:0]            wr_addr,
    input  logic [7:0]            wr_dat,
    input  logic                  wr_bit,
    input  logic                  bit_in,
    input  logic                  rd,
    input  logic [7:0]            rd_addr,
    input  logic [7:0]            rd_dat,
    input  logic                  rd_bit,
    input  logic                  bit_data_out,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [2:0]            ev_flags,
    output logic [TS_W-1:0]       ev_time,
    output logic [15:0]           ev_pc,
    output logic                  ev_wr_bit,
    output logic [7:0]            ev_wr_addr,
    output logic [7:0]            ev_wr_data,
    output logic                  ev_rd_bit,
    output logic [7:0]            ev_rd_addr,
    output logic [7:0]            ev_rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    localparam int C_DEPTH = 1 << DEPTH_LOG2;
    localparam int C_REC_W = 3 + TS_W + 16 + 17 + 17;

    logic [C_REC_W-1:0]    r_mem [C_DEPTH];
    logic [DEPTH_LOG2-1:0] r_head;
    logic [DEPTH_LOG2-1:0] r_tail;
    logic [DEPTH_LOG2:0]   r_level;
    logic [TS_W-1:0]       r_ts;
    logic [15:0]           r_last_pc;
    logic                  r_overflow;
    logic [15:0]           r_drop_count;

    logic                  w_pc_chg;
    logic                  w_req;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [7:0]            w_wr_data;
    logic [7:0]            w_rd_data;
    logic [C_REC_W-1:0]    w_rec;
    logic [C_REC_W-1:0]    w_head_rec;

    assign w_pc_chg  = (pc != r_last_pc);
    assign w_req     = enable & (w_pc_chg | wr | rd);
    assign w_full    = (r_level == (DEPTH_LOG2 + 1)'(C_DEPTH));
    assign w_pop     = ev_valid & ev_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push    = w_req & (~w_full | w_pop);
    assign w_drop    = w_req & w_full & ~w_pop;

    assign w_wr_data = wr_bit ? {7'b0, bit_in} : wr_dat;
    assign w_rd_data = rd_bit ? {7'b0, bit_data_out} : rd_dat;
    assign w_rec     = {rd, wr, w_pc_chg, r_ts, pc,
                        wr_bit, wr_addr, w_wr_data,
                        rd_bit, rd_addr, w_rd_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_level      <= '0;
            r_ts         <= '0;
            r_last_pc    <= 16'hFFFF;
            r_overflow   <= 1'b0;
            r_drop_count <= 16'h0000;
        end else if (clear) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_level      <= '0;
            r_ts         <= '0;
            r_last_pc    <= 16'hFFFF;
            r_overflow   <= 1'b0;
            r_drop_count <= 16'h0000;
        end else begin
            if (enable) begin
                r_ts      <= r_ts + TS_W'(1);
                r_last_pc <= pc;
            end
            if (w_push) begin
                r_tail <= r_tail + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_head <= r_head + DEPTH_LOG2'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
        end
    end

    // Record storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_tail] <= w_rec;
        end
    end

    assign ev_valid   = (r_level != '0);
    assign w_head_rec = ev_valid ? r_mem[r_head] : '0;

    assign {ev_flags, ev_time, ev_pc,
            ev_wr_bit, ev_wr_addr, ev_wr_data,
            ev_rd_bit, ev_rd_addr, ev_rd_data} = w_head_rec;

    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_oc8051_trace_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_oc8051_trace_capture
// Brief   : Directed scoreboard bench for the oc8051 trace recorder
// Revision: 1.0
// ============================================================================
module tb_oc8051_trace_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, clear;
    logic [15:0] pc;
    logic        wr, wr_bit, bit_in, rd, rd_bit, bit_data_out;
    logic [7:0]  wr_addr, wr_dat, rd_addr, rd_dat;
    logic        ev_valid, ev_ready;
    logic [2:0]  ev_flags;
    logic [31:0] ev_time;
    logic [15:0] ev_pc;
    logic        ev_wr_bit, ev_rd_bit;
    logic [7:0]  ev_wr_addr, ev_wr_data, ev_rd_addr, ev_rd_data;
    logic [6:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    logic [84:0] q[$];
    logic [31:0] m_ts;
    logic [15:0] m_last_pc;
    logic        m_ovf;
    logic [15:0] m_drop;

    always #5 clk = ~clk;

    oc8051_trace_capture #(.DEPTH_LOG2(6), .TS_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .pc(pc),
        .wr(wr), .wr_addr(wr_addr), .wr_dat(wr_dat), .wr_bit(wr_bit), .bit_in(bit_in),
        .rd(rd), .rd_addr(rd_addr), .rd_dat(rd_dat), .rd_bit(rd_bit),
        .bit_data_out(bit_data_out),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_flags(ev_flags), .ev_time(ev_time),
        .ev_pc(ev_pc), .ev_wr_bit(ev_wr_bit), .ev_wr_addr(ev_wr_addr),
        .ev_wr_data(ev_wr_data), .ev_rd_bit(ev_rd_bit), .ev_rd_addr(ev_rd_addr),
        .ev_rd_data(ev_rd_data), .level(level), .overflow(overflow),
        .drop_count(drop_count)
    );

    logic [84:0] w_obs;
    assign w_obs = {ev_flags, ev_time, ev_pc, ev_wr_bit, ev_wr_addr, ev_wr_data,
                    ev_rd_bit, ev_rd_addr, ev_rd_data};

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ts      = 32'd0;
        m_last_pc = 16'hFFFF;
        m_ovf     = 1'b0;
        m_drop    = 16'h0000;
    endtask

    // Advance one clock; the reference model consumes the inputs present now.
    task automatic tick();
        logic        req;
        logic [84:0] e;
        #1;
        if (clear) begin
            model_clear();
        end else begin
            chk("valid", ev_valid, q.size() != 0);
            if (q.size() != 0 && ev_ready) begin
                e = q.pop_front();
                chk("record", w_obs, e);
            end
            if (enable) begin
                req = (pc != m_last_pc) || wr || rd;
                if (req) begin
                    if (q.size() < 64) begin
                        q.push_back({rd, wr, pc != m_last_pc, m_ts, pc,
                                     wr_bit, wr_addr, wr_bit ? {7'b0, bit_in} : wr_dat,
                                     rd_bit, rd_addr, rd_bit ? {7'b0, bit_data_out} : rd_dat});
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                    end
                end
                m_last_pc = pc;
                m_ts      = m_ts + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        wr = 1'b0; wr_bit = 1'b0; bit_in = 1'b0; wr_addr = 8'h00; wr_dat = 8'h00;
        rd = 1'b0; rd_bit = 1'b0; bit_data_out = 1'b0; rd_addr = 8'h00; rd_dat = 8'h00;
    endtask

    task automatic status(input string tag);
        chk({tag, "_level"}, level, q.size());
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_drop"}, drop_count, m_drop);
    endtask

    task automatic drain(input string tag);
        ev_ready = 1'b1;
        enable   = 1'b0;
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        chk({tag, "_drained"}, level, 7'd0);
        ev_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; ev_ready = 1'b0; pc = 16'h0000;
        idle_strobes();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {ev_valid, w_obs, level, overflow, drop_count}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: stable pc yields a single pc-change record at time 0
        enable = 1'b1;
        pc     = 16'h0100;
        tick();
        chk("t1_latency", ev_valid, 1'b1);
        chk("t1_time", ev_time, 32'd0);
        repeat (4) tick();
        chk("t1_level", level, 7'd1);
        chk("t1_flags", ev_flags, 3'b001);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        status("t1");

        // 2: pc change, byte write and bit read merge into one record
        pc = 16'h0102;
        wr = 1'b1; wr_addr = 8'h30; wr_dat = 8'hA5;
        rd = 1'b1; rd_bit = 1'b1; rd_addr = 8'h20; rd_dat = 8'h5C; bit_data_out = 1'b1;
        tick();
        idle_strobes();
        chk("t2_level", level, 7'd1);
        chk("t2_flags", ev_flags, 3'b111);
        chk("t2_wr_data", ev_wr_data, 8'hA5);
        chk("t2_rd_data", ev_rd_data, 8'h01);
        chk("t2_rd_bit", ev_rd_bit, 1'b1);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        status("t2");

        // 3: overfill with the consumer stalled
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 70; i++) begin
            pc = 16'h1000 + 16'(i);
            tick();
        end
        chk("t3_level", level, 7'd64);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_drop", drop_count, 16'd6);
        chk("t3_head_time", ev_time, 32'd0);

        // 4: at full, pop and push together every cycle
        ev_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = 16'h2000 + 16'(i);
            tick();
            chk("t4_level", level, 7'd64);
        end
        chk("t4_drop", drop_count, 16'd6);
        drain("t3");
        status("t4");

        // 5: clear beats a same-edge push and pop
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = 16'h3000 + 16'(i);
            tick();
        end
        chk("t5_level_pre", level, 7'd10);
        chk("t5_ovf_pre", overflow, 1'b1);
        clear = 1'b1; ev_ready = 1'b1; pc = 16'h3100; wr = 1'b1; wr_dat = 8'h77;
        tick();
        clear = 1'b0; ev_ready = 1'b0; idle_strobes();
        chk("t5_level", level, 7'd0);
        chk("t5_valid", ev_valid, 1'b0);
        chk("t5_ovf", overflow, 1'b0);
        chk("t5_drop", drop_count, 16'd0);
        pc = 16'h0200;
        tick();
        chk("t5_time", ev_time, 32'd0);
        chk("t5_pc", ev_pc, 16'h0200);
        drain("t5");

        // 6: drop counter saturation, then asynchronous reset
        enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pc = 16'h4000 + 16'(i);
            tick();
        end
        status("t6_full");
        force dut.r_drop_count = 16'hFFFE;
        #1;
        release dut.r_drop_count;
        m_drop = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            pc = 16'h5000 + 16'(i);
            tick();
        end
        chk("t6_drop_sat", drop_count, 16'hFFFF);
        status("t6");
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", {ev_valid, w_obs, level, overflow, drop_count}, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oc8051_trace_capture.md
Name: oc8051_trace_capture

Overview:
- Synthesizable on-chip trace recorder for the oc8051 core.
- Watches the core's program counter and its internal-RAM/SFR read and write strobes every cycle.
- Each active cycle is packed into one timestamped record and stored in a circular FIFO.
- Records drain over a valid/ready port to the downstream trace logger/formatter, so simulation and FPGA trace share one event source.

Parameters:
DEPTH_LOG2, 6, FIFO depth = 2**DEPTH_LOG2 records (64)
TS_W, 32, timestamp counter width

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  capture enable; when low, no records are pushed and the timestamp holds
clear  in  1  synchronous flush of FIFO, overflow, drop_count, timestamp and last_pc
pc  in  16  core program counter
wr  in  1  memory write strobe
wr_addr  in  8  write address
wr_dat  in  8  write byte data
wr_bit  in  1  write is a bit op (sfr wr_bit_r)
bit_in  in  1  bit value for bit write
rd  in  1  memory read strobe
rd_addr  in  8  read address
rd_dat  in  8  read byte data
rd_bit  in  1  read is a bit op
bit_data_out  in  1  bit value for bit read
ev_valid  out  1  head record available
ev_ready  in  1  consumer accepts head record
ev_flags  out  3  {rd, wr, pc_chg} present in record
ev_time  out  TS_W  timestamp of record
ev_pc  out  16  pc at capture
ev_wr_bit  out  1  write was a bit op
ev_wr_addr  out  8  write address
ev_wr_data  out  8  write data; bit op: {7'b0, bit_in}
ev_rd_bit  out  1  read was a bit op
ev_rd_addr  out  8  read address
ev_rd_data  out  8  read data; bit op: {7'b0, bit_data_out}
level  out  DEPTH_LOG2+1  records currently stored
overflow  out  1  sticky: at least one record dropped
drop_count  out  16  dropped records, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n low): all outputs 0; FIFO empty; timestamp 0; last_pc = 16'hFFFF.
- Timestamp:
  - Increments by 1 every clk while enable=1; holds while enable=0.
  - Wraps modulo 2**TS_W, with no flag on wrap.
  - A record carries the timestamp value before that edge's increment.
- Record generation, evaluated at each posedge with enable=1:
  - pc_chg = (pc != last_pc); wrf = wr; rdf = rd.
  - If any flag is set, one record is pushed.
  - last_pc <= pc every enabled cycle.
  - All three events in one cycle go into a single record; no event is ever split.
- Push acceptance:
  - Accepted if level < 2**DEPTH_LOG2, or if a pop occurs on the same edge.
  - Otherwise the record is dropped, overflow <= 1 and drop_count increments, saturating at FFFF.
- Pop: on a posedge with ev_valid & ev_ready, the head pointer advances.
- Simultaneous push and pop: level is unchanged, and both pointers advance (including at full and when empty with level 0 → the pop is ignored, push lands).
- Output is first-word-fall-through:
  - ev_* show the head entry combinationally from storage whenever ev_valid=1.
  - ev_* are don't-care when ev_valid=0.
- Latency: an event captured at edge N with the FIFO empty gives ev_valid=1 in the cycle after edge N.
- Pointers are DEPTH_LOG2 bits and wrap naturally; level is tracked explicitly, full = level == depth.
- clear:
  - Takes priority over push and pop on the same edge.
  - After the edge: level=0, ev_valid=0, overflow=0, drop_count=0, timestamp=0, last_pc=FFFF.
- enable falling: stored records remain drainable; no new pushes.
- Reset mid-operation discards all records immediately, asynchronously.
- Record storage is a plain register/RAM array with no reset requirement on contents.

Test Plan:
1. Reset, enable=1, pc fixed at 16'h0100 for 5 cycles, no wr/rd → exactly one record: flags=3'b001, pc=0100, time=0.
2. Same cycle: pc 0100→0102, wr=1 wr_addr=8'h30 wr_dat=8'hA5, rd=1 rd_bit=1 rd_addr=8'h20 bit_data_out=1 → one record: flags=3'b111, wr_data=A5, rd_data=01, rd_bit=1.
3. ev_ready=0, force pc change every cycle for 70 cycles (DEPTH_LOG2=6) → level=64, overflow=1, drop_count=6; drained records have times 0..63 in order.
4. At full, ev_ready=1 while pushing each cycle → level stays 64, no further drops, ev_time increments by 1 per pop.
5. 10 records stored, assert clear together with a pushing event and ev_ready=1 → next cycle level=0, ev_valid=0, overflow=0; next pc (any value ≠ FFFF) logs with time=0.
6. Preload drop_count near saturation (force 16'hFFFE), drop 3 more records → drop_count=FFFF; rst_n pulse low mid-cycle → all outputs 0 immediately, asynchronously.
